// File: rtl/me_ctrl.sv
// Player craft controller: turns held keys into rate-limited round-robin move
// strobes and sequences the craft through alive, destroy, respawn and game over.
module me_ctrl #(
   parameter int unsigned LIVES         = 3,
   parameter int unsigned MOVE_DIV      = 4,
   parameter int unsigned NORMAL_TICKS  = 64,
   parameter int unsigned DESTROY_TICKS = 16,
   parameter int unsigned INVINC_TICKS  = 128,
   parameter int unsigned BLINK_TICKS   = 8
) (
   input  logic       clk_run,
   input  logic       rst,
   input  logic [3:0] key_i,
   input  logic       collide_i,
   input  logic       game_start_i,
   output logic       move_en_o,
   output logic [1:0] direct_o,
   output logic       en_o,
   output logic [2:0] frame_sel_o,
   output logic       respawn_o,
   output logic [1:0] lives_o,
   output logic       invincible_o,
   output logic       game_over_o
);

   localparam int unsigned DIV_W   = (MOVE_DIV > 1)      ? $clog2(MOVE_DIV)      : 1;
   localparam int unsigned NORM_W  = (NORMAL_TICKS > 1)  ? $clog2(NORMAL_TICKS)  : 1;
   localparam int unsigned DEST_W  = (DESTROY_TICKS > 1) ? $clog2(DESTROY_TICKS) : 1;
   localparam int unsigned INV_W   = (INVINC_TICKS > 1)  ? $clog2(INVINC_TICKS)  : 1;
   localparam int unsigned BLINK_W = (BLINK_TICKS > 1)   ? $clog2(BLINK_TICKS)   : 1;

   // Direction codes double as round-robin positions: up, right, down, left.
   localparam logic [1:0] DIR_UP = 2'd0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ALIVE   = 3'd1,
      S_DYING   = 3'd2,
      S_RESPAWN = 3'd3,
      S_OVER    = 3'd4
   } state_e;

   state_e             state_q;
   logic [DIV_W-1:0]   div_q;
   logic [NORM_W-1:0]  norm_q;
   logic [DEST_W-1:0]  dest_q;
   logic [INV_W-1:0]   inv_q;
   logic [BLINK_W-1:0] blink_q;
   logic [1:0]         ptr_q;

   logic               move_en_q;
   logic [1:0]         direct_q;
   logic               en_q;
   logic [2:0]         frame_q;
   logic               respawn_q;
   logic [1:0]         lives_q;
   logic               invincible_q;
   logic               game_over_q;

   logic [3:0]         req_c;
   logic [1:0]         idx_c;
   logic [1:0]         grant_c;
   logic               grant_vld_c;
   logic               div_wrap_c;
   logic               norm_wrap_c;
   logic               dest_wrap_c;
   logic               inv_last_c;
   logic               blink_wrap_c;

   // Opposite keys cancel; then pick the first request at or after the pointer.
   always_comb begin
      req_c       = {key_i[0], key_i[1], key_i[2], key_i[3]};
      idx_c       = ptr_q;
      grant_c     = ptr_q;
      grant_vld_c = 1'b0;
      if (req_c[0] && req_c[2]) begin
         req_c[0] = 1'b0;
         req_c[2] = 1'b0;
      end
      if (req_c[1] && req_c[3]) begin
         req_c[1] = 1'b0;
         req_c[3] = 1'b0;
      end
      for (int k = 3; k >= 0; k--) begin
         idx_c = ptr_q + 2'(k);
         if (req_c[idx_c]) begin
            grant_vld_c = 1'b1;
            grant_c     = idx_c;
         end
      end
   end

   assign div_wrap_c   = (div_q   == DIV_W'(MOVE_DIV - 1));
   assign norm_wrap_c  = (norm_q  == NORM_W'(NORMAL_TICKS - 1));
   assign dest_wrap_c  = (dest_q  == DEST_W'(DESTROY_TICKS - 1));
   assign inv_last_c   = (inv_q   == INV_W'(INVINC_TICKS - 1));
   assign blink_wrap_c = (blink_q == BLINK_W'(BLINK_TICKS - 1));

   always_ff @(posedge clk_run or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         norm_q       <= '0;
         dest_q       <= '0;
         inv_q        <= '0;
         blink_q      <= '0;
         ptr_q        <= DIR_UP;
         move_en_q    <= 1'b0;
         direct_q     <= DIR_UP;
         en_q         <= 1'b0;
         frame_q      <= 3'd0;
         respawn_q    <= 1'b0;
         lives_q      <= 2'd0;
         invincible_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         move_en_q <= 1'b0;
         respawn_q <= 1'b0;
         case (state_q)
            S_IDLE, S_OVER: begin
               if (game_start_i) begin
                  state_q     <= S_ALIVE;
                  lives_q     <= 2'(LIVES);
                  respawn_q   <= 1'b1;
                  en_q        <= 1'b1;
                  frame_q     <= 3'd0;
                  game_over_q <= 1'b0;
                  div_q       <= '0;
                  norm_q      <= '0;
               end
            end
            S_ALIVE, S_RESPAWN: begin
               if ((state_q == S_ALIVE) && collide_i) begin
                  // Hit beats any move step scheduled for this cycle.
                  state_q <= S_DYING;
                  lives_q <= lives_q - 2'd1;
                  frame_q <= 3'd2;
                  en_q    <= 1'b1;
                  div_q   <= '0;
                  norm_q  <= '0;
                  dest_q  <= '0;
               end else begin
                  if (div_wrap_c) begin
                     div_q <= '0;
                     if (grant_vld_c) begin
                        move_en_q <= 1'b1;
                        direct_q  <= grant_c;
                        ptr_q     <= grant_c + 2'd1;
                     end
                  end else begin
                     div_q <= div_q + DIV_W'(1);
                  end
                  if (norm_wrap_c) begin
                     norm_q  <= '0;
                     frame_q <= {2'b00, ~frame_q[0]};
                  end else begin
                     norm_q <= norm_q + NORM_W'(1);
                  end
                  if (state_q == S_RESPAWN) begin
                     if (inv_last_c) begin
                        state_q      <= S_ALIVE;
                        invincible_q <= 1'b0;
                        en_q         <= 1'b1;
                        inv_q        <= '0;
                        blink_q      <= '0;
                     end else begin
                        inv_q <= inv_q + INV_W'(1);
                        if (blink_wrap_c) begin
                           blink_q <= '0;
                           en_q    <= ~en_q;
                        end else begin
                           blink_q <= blink_q + BLINK_W'(1);
                        end
                     end
                  end
               end
            end
            S_DYING: begin
               if (dest_wrap_c) begin
                  dest_q <= '0;
                  if (frame_q == 3'd4) begin
                     frame_q <= 3'd0;
                     if (lives_q == 2'd0) begin
                        state_q     <= S_OVER;
                        en_q        <= 1'b0;
                        game_over_q <= 1'b1;
                     end else begin
                        state_q      <= S_RESPAWN;
                        respawn_q    <= 1'b1;
                        invincible_q <= 1'b1;
                        en_q         <= 1'b1;
                        inv_q        <= '0;
                        blink_q      <= '0;
                        div_q        <= '0;
                        norm_q       <= '0;
                     end
                  end else begin
                     frame_q <= frame_q + 3'd1;
                  end
               end else begin
                  dest_q <= dest_q + DEST_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign move_en_o    = move_en_q;
   assign direct_o     = direct_q;
   assign en_o         = en_q;
   assign frame_sel_o  = frame_q;
   assign respawn_o    = respawn_q;
   assign lives_o      = lives_q;
   assign invincible_o = invincible_q;
   assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_me_ctrl.sv
// Self-checking bench for me_ctrl: random key/collision traffic compared every
// cycle against a phase-and-elapsed-time model of the craft controller.
module tb_me_ctrl;

   localparam int LIVES = 3;
   localparam int M     = 4;
   localparam int NT    = 64;
   localparam int DT    = 16;
   localparam int IT    = 128;
   localparam int BT    = 8;

   localparam int P_IDLE = 0, P_ALIVE = 1, P_DYING = 2, P_RESP = 3, P_OVER = 4;
   localparam logic [3:0] K_UP = 4'b1000, K_RIGHT = 4'b0100, K_DOWN = 4'b0010, K_LEFT = 4'b0001;

   logic       clk_run = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key = 4'b0;
   logic       collide = 1'b0;
   logic       start = 1'b0;

   logic       move_en_o;
   logic [1:0] direct_o;
   logic       en_o;
   logic [2:0] frame_sel_o;
   logic       respawn_o;
   logic [1:0] lives_o;
   logic       invincible_o;
   logic       game_over_o;

   int checks = 0;
   int errors = 0;

   // Model: current phase, cycles spent in it, cycles since the craft became
   // active (alive or respawning), plus the registered move/respawn events.
   int m_phase, m_t, m_act, m_lives, m_ptr, m_dir;
   bit m_mv, m_resp;

   me_ctrl #(
      .LIVES(LIVES), .MOVE_DIV(M), .NORMAL_TICKS(NT),
      .DESTROY_TICKS(DT), .INVINC_TICKS(IT), .BLINK_TICKS(BT)
   ) dut (
      .clk_run      (clk_run),
      .rst          (rst),
      .key_i        (key),
      .collide_i    (collide),
      .game_start_i (start),
      .move_en_o    (move_en_o),
      .direct_o     (direct_o),
      .en_o         (en_o),
      .frame_sel_o  (frame_sel_o),
      .respawn_o    (respawn_o),
      .lives_o      (lives_o),
      .invincible_o (invincible_o),
      .game_over_o  (game_over_o)
   );

   always #5 clk_run = ~clk_run;

   task automatic model_reset();
      m_phase = P_IDLE; m_t = 0; m_act = 0; m_lives = 0;
      m_ptr = 0; m_dir = 0; m_mv = 0; m_resp = 0;
   endtask

   task automatic model_step(input logic [3:0] k, input bit c, input bit s);
      bit ok[4];
      int best;
      m_mv = 0;
      m_resp = 0;
      case (m_phase)
         P_IDLE, P_OVER: if (s) begin
            m_phase = P_ALIVE; m_t = 0; m_act = 0; m_lives = LIVES; m_resp = 1;
         end
         P_ALIVE, P_RESP: begin
            if (m_phase == P_ALIVE && c) begin
               m_phase = P_DYING; m_t = 0; m_lives = m_lives - 1;
            end else begin
               if (m_act % M == M - 1) begin
                  ok[0] = k[3] && !k[1];
                  ok[2] = k[1] && !k[3];
                  ok[1] = k[2] && !k[0];
                  ok[3] = k[0] && !k[2];
                  best = -1;
                  for (int d = 0; d < 4; d++)
                     if (ok[d] && (best < 0 || ((d - m_ptr + 4) % 4) < ((best - m_ptr + 4) % 4)))
                        best = d;
                  if (best >= 0) begin
                     m_mv = 1; m_dir = best; m_ptr = (best + 1) % 4;
                  end
               end
               m_act++;
               if (m_phase == P_RESP && m_t == IT - 1) begin
                  m_phase = P_ALIVE; m_t = 0;
               end else begin
                  m_t++;
               end
            end
         end
         P_DYING: begin
            if (m_t == 3 * DT - 1) begin
               m_t = 0;
               if (m_lives == 0) m_phase = P_OVER;
               else begin
                  m_phase = P_RESP; m_act = 0; m_resp = 1;
               end
            end else begin
               m_t++;
            end
         end
         default: ;
      endcase
   endtask

   function automatic logic [11:0] exp_vec();
      logic       e_en;
      logic [2:0] e_fr;
      case (m_phase)
         P_ALIVE: begin e_en = 1'b1; e_fr = 3'((m_act / NT) % 2); end
         P_RESP:  begin e_en = ((m_t / BT) % 2 == 0); e_fr = 3'((m_act / NT) % 2); end
         P_DYING: begin e_en = 1'b1; e_fr = 3'(2 + m_t / DT); end
         default: begin e_en = 1'b0; e_fr = 3'd0; end
      endcase
      return {m_mv, 2'(m_dir), e_en, e_fr, m_resp, 2'(m_lives),
              (m_phase == P_RESP), (m_phase == P_OVER)};
   endfunction

   function automatic logic [11:0] obs_vec();
      return {move_en_o, direct_o, en_o, frame_sel_o, respawn_o, lives_o,
              invincible_o, game_over_o};
   endfunction

   task automatic cycle(input logic [3:0] k, input bit c, input bit s);
      @(negedge clk_run);
      key = k; collide = c; start = s;
      @(posedge clk_run);
      model_step(k, c, s);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk_run);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_state got %h exp %h", obs_vec(), exp_vec());
      end
      @(negedge clk_run);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle(4'b0000, 1'b1, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL idle_ignore_collide cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_start_up();
      cycle(4'b0000, 1'b0, 1'b1);
      checks++;
      if (lives_o !== 2'd3 || respawn_o !== 1'b1 || en_o !== 1'b1) begin
         errors++;
         $display("FAIL start lives %0d resp %b en %b exp 3 1 1", lives_o, respawn_o, en_o);
      end
      for (int i = 0; i < 24; i++) begin
         cycle(K_UP, 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL up_only cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_arbitration();
      logic [3:0] pats [5];
      pats[0] = K_UP | K_RIGHT;
      pats[1] = K_UP | K_DOWN | K_LEFT;
      pats[2] = 4'b1111;
      pats[3] = K_DOWN | K_LEFT;
      pats[4] = K_LEFT | K_RIGHT | K_DOWN;
      foreach (pats[p]) begin
         for (int i = 0; i < 20; i++) begin
            cycle(pats[p], 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL arb pat %b cyc %0d got %h exp %h", pats[p], i, obs_vec(), exp_vec());
            end
         end
      end
      for (int i = 0; i < 200; i++) begin
         cycle(4'($urandom), 1'b0, ($urandom_range(0, 15) == 0));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL arb_random cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_collide_respawn();
      cycle(K_UP, 1'b1, 1'b0);
      checks++;
      if (lives_o !== 2'd2 || frame_sel_o !== 3'd2 || move_en_o !== 1'b0) begin
         errors++;
         $display("FAIL hit lives %0d frame %0d mv %b exp 2 2 0", lives_o, frame_sel_o, move_en_o);
      end
      for (int i = 0; i < 3 * DT + IT + 30; i++) begin
         cycle(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL dying_respawn cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_collide_on_step();
      int n = 0;
      while (!(m_phase == P_ALIVE && m_act % M == M - 1) && n < 400) begin
         cycle(K_UP, 1'b0, 1'b0);
         n++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL step_wait cyc %0d got %h exp %h", n, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL step_wait timeout phase %0d exp %0d", m_phase, P_ALIVE);
      end else begin
         cycle(K_UP, 1'b1, 1'b0);
         checks++;
         if (move_en_o !== 1'b0 || frame_sel_o !== 3'd2 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL hit_on_step got %h exp %h", obs_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 3 * DT + IT + 10; i++) begin
         cycle(4'($urandom), 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL after_step_hit cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_game_over();
      int n = 0;
      while (m_phase != P_OVER && n < 2000) begin
         cycle(4'($urandom), (m_phase == P_ALIVE), 1'b0);
         n++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL to_over cyc %0d got %h exp %h", n, obs_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 12; i++) begin
         cycle(K_UP | K_RIGHT, 1'b1, 1'b0);
         checks++;
         if (game_over_o !== 1'b1 || en_o !== 1'b0 || move_en_o !== 1'b0) begin
            errors++;
            $display("FAIL over go %b en %b mv %b exp 1 0 0", game_over_o, en_o, move_en_o);
         end
      end
      cycle(4'b0000, 1'b0, 1'b1);
      checks++;
      if (lives_o !== 2'd3 || game_over_o !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL restart got %h exp %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_async_reset();
      cycle(K_LEFT, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cycle(K_LEFT, 1'b0, 1'b0);
      @(negedge clk_run);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL async_reset got %h exp %h", obs_vec(), exp_vec());
      end
      @(negedge clk_run);
      rst = 1'b0;
      cycle(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         cycle(K_RIGHT | K_DOWN, 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random_play();
      for (int i = 0; i < 2500; i++) begin
         cycle(4'($urandom), ($urandom_range(0, 40) == 0), ($urandom_range(0, 30) == 0));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_play cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_up();
      test_arbitration();
      test_collide_respawn();
      test_collide_on_step();
      test_game_over();
      test_async_reset();
      test_random_play();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
